// File: rtl/fpu_mem_arbiter.sv
// Round-robin burst arbiter sharing one line-wide memory port between FPU requesters.
// Optional performance counters are built when FPU_ARB_PERF_EN is defined.
module fpu_mem_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int LINE_BYTES = 64,
  parameter int DATA_W     = 512
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        wr_i,
  input  logic [NUM_REQ*32-1:0]     addr_i,
  input  logic [NUM_REQ*8-1:0]      beats_i,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        beat_done_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      busy_o,
  output logic                      mem_req_o,
  output logic                      mem_wr_o,
  output logic [31:0]               mem_addr_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  input  logic                      mem_valid_i,
  input  logic [DATA_W-1:0]         mem_rdata_i,
`ifdef FPU_ARB_PERF_EN
  output logic [31:0]               perf_busy_cycles_o,
  output logic [NUM_REQ*16-1:0]     perf_bursts_o,
`endif
  output logic [1:0]                dbg_state_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [31:0] STEP = 32'(LINE_BYTES);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_win;
  logic [31:0]      r_addr;
  logic             r_wr;
  logic [8:0]       r_remaining;

  logic              w_found;
  logic [IDX_W-1:0]  w_pick;
  logic [31:0]       w_sel_addr;
  logic              w_sel_wr;
  logic [7:0]        w_sel_beats;
  logic [DATA_W-1:0] w_win_wdata;
  logic [NUM_REQ-1:0] w_gnt;
  logic              w_issue;
  logic              w_last_beat;

  // Walk downward so the requester closest to r_ptr (upward, wrapping) wins.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(r_ptr) + i) % NUM_REQ;
      if (req_i[idx]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wr    = 1'b0;
    w_sel_beats = '0;
    w_win_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick == IDX_W'(i)) begin
        w_sel_addr  = addr_i[i*32 +: 32];
        w_sel_wr    = wr_i[i];
        w_sel_beats = beats_i[i*8 +: 8];
      end
      if (r_win == IDX_W'(i)) begin
        w_win_wdata = wdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_issue     = (r_state == ST_ISSUE);
  assign w_last_beat = (r_remaining == 9'd1);

  always_comb begin
    w_gnt = '0;
    if (w_issue) begin
      w_gnt[r_win] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_win       <= '0;
      r_addr      <= '0;
      r_wr        <= 1'b0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_win       <= w_pick;
            r_addr      <= w_sel_addr;
            r_wr        <= w_sel_wr;
            r_remaining <= (w_sel_beats == 8'd0) ? 9'd256 : {1'b0, w_sel_beats};
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_valid_i) begin
            if (w_last_beat) begin
              r_state <= ST_RELEASE;
            end else begin
              r_addr      <= r_addr + STEP;
              r_remaining <= r_remaining - 9'd1;
            end
          end
        end
        ST_RELEASE: begin
          r_ptr   <= (r_win == IDX_W'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt_o       = w_gnt;
  assign beat_done_o = w_gnt & {NUM_REQ{mem_valid_i}};
  assign rdata_o     = mem_rdata_i;
  assign busy_o      = w_issue;
  assign mem_req_o   = w_issue;
  assign mem_wr_o    = r_wr;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = w_issue ? w_win_wdata : '0;
  assign dbg_state_o = r_state;

`ifdef FPU_ARB_PERF_EN
  logic [31:0]           r_perf_busy;
  logic [NUM_REQ*16-1:0] r_perf_bursts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_busy   <= '0;
      r_perf_bursts <= '0;
    end else begin
      if (w_issue && (r_perf_busy != 32'hFFFF_FFFF)) begin
        r_perf_busy <= r_perf_busy + 32'd1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_issue && mem_valid_i && w_last_beat && (r_win == IDX_W'(i))) begin
          r_perf_bursts[i*16 +: 16] <= r_perf_bursts[i*16 +: 16] + 16'd1;
        end
      end
    end
  end

  assign perf_busy_cycles_o = r_perf_busy;
  assign perf_bursts_o      = r_perf_bursts;
`endif

endmodule

// File: tb/tb_fpu_mem_arbiter.sv
// Directed-plus-random bench for fpu_mem_arbiter against a round-robin burst model.
module tb_fpu_mem_arbiter;
  localparam int NUM_REQ    = 3;
  localparam int LINE_BYTES = 64;
  localparam int DATA_W     = 512;
  localparam int W          = DATA_W;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ-1:0]        wr_i;
  logic [NUM_REQ*32-1:0]     addr_i;
  logic [NUM_REQ*8-1:0]      beats_i;
  logic [NUM_REQ*DATA_W-1:0] wdata_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic [NUM_REQ-1:0]        beat_done_o;
  logic [DATA_W-1:0]         rdata_o;
  logic                      busy_o;
  logic                      mem_req_o;
  logic                      mem_wr_o;
  logic [31:0]               mem_addr_o;
  logic [DATA_W-1:0]         mem_wdata_o;
  logic                      mem_valid_i;
  logic [DATA_W-1:0]         mem_rdata_i;
  logic [1:0]                dbg_state_o;
`ifdef FPU_ARB_PERF_EN
  logic [31:0]               perf_busy_cycles_o;
  logic [NUM_REQ*16-1:0]     perf_bursts_o;
`endif

  fpu_mem_arbiter #(.NUM_REQ(NUM_REQ), .LINE_BYTES(LINE_BYTES), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req_i), .wr_i(wr_i), .addr_i(addr_i), .beats_i(beats_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .beat_done_o(beat_done_o), .rdata_o(rdata_o), .busy_o(busy_o),
    .mem_req_o(mem_req_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_valid_i(mem_valid_i), .mem_rdata_i(mem_rdata_i),
`ifdef FPU_ARB_PERF_EN
    .perf_busy_cycles_o(perf_busy_cycles_o), .perf_bursts_o(perf_bursts_o),
`endif
    .dbg_state_o(dbg_state_o)
  );

  // per-requester stimulus, packed onto the flat ports
  logic [31:0]       t_addr [NUM_REQ];
  logic [7:0]        t_beats[NUM_REQ];
  logic [DATA_W-1:0] t_wline[NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_i[i*32 +: 32]          = t_addr[i];
      beats_i[i*8 +: 8]           = t_beats[i];
      wdata_i[i*DATA_W +: DATA_W] = t_wline[i];
    end
  end

  // scoreboard
  int          n_vec;
  int          n_err;
  int          ref_ptr;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_line();
    logic [DATA_W-1:0] v;
    for (int k = 0; k < DATA_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // reference arbitration: first set bit upward from ptr, wrapping
  function automatic int model_pick(input logic [NUM_REQ-1:0] r, input int p);
    for (int off = 0; off < NUM_REQ; off++) begin
      if (r[(p + off) % NUM_REQ]) return (p + off) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // drive and check one granted burst; entered at the first ISSUE negedge
  task automatic serve(input int win, input int nbeats, input int gap_lo, input int gap_hi,
                       input logic keep, input logic mid_en, input logic [NUM_REQ-1:0] mid_req);
    logic [DATA_W-1:0]  rd;
    logic [31:0]        a;
    logic [NUM_REQ-1:0] oh;
    int                 g;
    oh = '0;
    oh[win] = 1'b1;
    exp_q.delete();
    a = t_addr[win];
    for (int k = 0; k < nbeats; k++) begin
      exp_q.push_back(a);
      a = a + 32'(LINE_BYTES);
    end
    for (int k = 0; k < nbeats; k++) begin
      chk("gnt", W'(gnt_o), W'(oh));
      chk("busy", W'(busy_o), W'(1'b1));
      chk("mem_req", W'(mem_req_o), W'(1'b1));
      chk("mem_wr", W'(mem_wr_o), W'(wr_i[win]));
      chk("mem_addr", W'(mem_addr_o), W'(exp_q.pop_front()));
      if (wr_i[win]) chk("mem_wdata", mem_wdata_o, t_wline[win]);
      g = $urandom_range(gap_hi, gap_lo);
      repeat (g) begin
        tick();
        chk("no_done", W'(beat_done_o), W'(0));
      end
      rd = rand_line();
      mem_rdata_i = rd;
      mem_valid_i = 1'b1;
      #1;
      chk("beat_done", W'(beat_done_o), W'(oh));
      chk("rdata", rdata_o, rd);
      tick();
      mem_valid_i = 1'b0;
      if (wr_i[win]) t_wline[win] = rand_line();
      if (mid_en && k == 0) req_i = mid_req;
      if (k == nbeats - 1 && !keep) req_i[win] = 1'b0;
      #1;
    end
    chk("rel_gnt", W'(gnt_o), W'(0));
    chk("rel_busy", W'(busy_o), W'(1'b0));
    chk("rel_mem_req", W'(mem_req_o), W'(1'b0));
    tick();
    chk("idle_gnt", W'(gnt_o), W'(0));
    ref_ptr = (win + 1) % NUM_REQ;
  endtask

  // request already set at an IDLE negedge; predicts the winner and serves it
  task automatic burst(input int gap_lo, input int gap_hi, input logic keep,
                       input logic mid_en, input logic [NUM_REQ-1:0] mid_req);
    int w;
    int n;
    w = model_pick(req_i, ref_ptr);
    n = (t_beats[w] == 8'd0) ? 256 : int'(t_beats[w]);
    #1;
    chk("pre_gnt", W'(gnt_o), W'(0));
    tick();
    serve(w, n, gap_lo, gap_hi, keep, mid_en, mid_req);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    ref_ptr = 0;
    rst_n = 1'b0;
    req_i = '0;
    wr_i = '0;
    mem_valid_i = 1'b0;
    mem_rdata_i = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      t_addr[i] = '0;
      t_beats[i] = '0;
      t_wline[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", W'(gnt_o), W'(0));
    chk("rst_done", W'(beat_done_o), W'(0));
    chk("rst_busy", W'(busy_o), W'(1'b0));
    chk("rst_mem_req", W'(mem_req_o), W'(1'b0));
    chk("rst_mem_wr", W'(mem_wr_o), W'(1'b0));
    chk("rst_mem_addr", W'(mem_addr_o), W'(0));
    chk("rst_mem_wdata", mem_wdata_o, W'(0));
    rst_n = 1'b1;
    tick();

    // all three requesting from reset, one beat each, held high
    for (int i = 0; i < NUM_REQ; i++) begin
      t_addr[i] = {$urandom_range(0, 32'h03FF_FFFF), 6'd0};
      t_beats[i] = 8'd1;
    end
    req_i = 3'b111;
    for (int r = 0; r < 6; r++) burst(0, 2, 1'b1, 1'b0, '0);
    req_i = '0;

    // memory completion while idle is ignored
    mem_valid_i = 1'b1;
    #1;
    chk("idle_valid_done", W'(beat_done_o), W'(0));
    tick();
    mem_valid_i = 1'b0;
    chk("idle_valid_gnt", W'(gnt_o), W'(0));
    chk("idle_valid_req", W'(mem_req_o), W'(1'b0));

    // single three-beat read, memory answering two cycles after each request
    t_addr[0] = 32'h1000_0000;
    t_beats[0] = 8'd3;
    req_i = 3'b001;
    burst(2, 2, 1'b0, 1'b0, '0);

    // two-beat write from requester 2, line changes after the first beat
    wr_i = 3'b100;
    t_addr[2] = 32'h2000_0100;
    t_beats[2] = 8'd2;
    t_wline[2] = rand_line();
    req_i = 3'b100;
    burst(0, 1, 1'b0, 1'b0, '0);
    wr_i = '0;

    // address wraps through zero
    t_addr[1] = 32'hFFFF_FFC0;
    t_beats[1] = 8'd2;
    req_i = 3'b010;
    burst(0, 3, 1'b0, 1'b0, '0);

    // requests change mid-burst: owner drops, others raise; burst still completes
    t_addr[0] = 32'h3000_0000;
    t_beats[0] = 8'd3;
    t_beats[1] = 8'd1;
    t_beats[2] = 8'd1;
    req_i = 3'b001;
    burst(0, 1, 1'b0, 1'b1, 3'b110);
    burst(0, 1, 1'b0, 1'b0, '0);
    burst(0, 1, 1'b0, 1'b0, '0);

    // beats_i = 0 means 256 beats
    t_addr[0] = 32'h4000_0000;
    t_beats[0] = 8'd0;
    req_i = 3'b001;
    burst(0, 0, 1'b0, 1'b0, '0);

    // leave the pointer at 2 before the reset test
    req_i = 3'b010;
    burst(0, 0, 1'b0, 1'b0, '0);

    // reset after the first of four beats abandons the burst
    t_addr[0] = 32'h5000_0000;
    t_beats[0] = 8'd4;
    req_i = 3'b001;
    tick();
    chk("rb_gnt", W'(gnt_o), W'(3'b001));
    mem_valid_i = 1'b1;
    tick();
    mem_valid_i = 1'b0;
    #1;
    chk("rb_addr2", W'(mem_addr_o), W'(32'h5000_0040));
    mem_valid_i = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rb_gnt_drop", W'(gnt_o), W'(0));
    chk("rb_req_drop", W'(mem_req_o), W'(1'b0));
    chk("rb_busy_drop", W'(busy_o), W'(1'b0));
    chk("rb_no_done", W'(beat_done_o), W'(0));
    mem_valid_i = 1'b0;
    req_i = '0;
    tick();
    rst_n = 1'b1;
    ref_ptr = 0;
    tick();
    t_beats[1] = 8'd1;
    t_beats[2] = 8'd1;
    req_i = 3'b110;
    burst(0, 1, 1'b0, 1'b0, '0);
    req_i = '0;
    tick();

    // random mix of requesters, directions, lengths and addresses
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        t_addr[i] = {$urandom, 6'd0} [31:0];
        t_beats[i] = 8'($urandom_range(1, 4));
        t_wline[i] = rand_line();
      end
      wr_i = 3'($urandom_range(0, 7));
      req_i = 3'($urandom_range(1, 7));
      burst(0, 2, 1'b1, 1'b0, '0);
    end
    req_i = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_mem_arbiter.md
Name: fpu_mem_arbiter

Overview:
- Shares the single line-wide mapped memory port between up to NUM_REQ requesters: FPU configuration loader, FPU read-request engine and FPU write-request engine.
- Grants whole bursts of 512-bit line beats with round-robin fairness.
- Sequences one line transaction at a time on the memory side.
- Sits between the FPU controller's request logic and the memory-mapped interface.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- LINE_BYTES, 64, byte increment of the address per beat.
- DATA_W, 512, line width in bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_i  in  NUM_REQ  per-requester request, held until its last beat_done_o
- wr_i  in  NUM_REQ  per-requester direction, 1 = write
- addr_i  in  NUM_REQ*32  per-requester burst start address
- beats_i  in  NUM_REQ*8  per-requester burst length; 0 means 256
- wdata_i  in  NUM_REQ*DATA_W  per-requester current write line
- gnt_o  out  NUM_REQ  one-hot grant, held for the whole burst
- beat_done_o  out  NUM_REQ  one-hot pulse, one per completed beat
- rdata_o  out  DATA_W  read line; valid with beat_done_o
- busy_o  out  1  high while any burst is granted
- mem_req_o  out  1  memory beat request
- mem_wr_o  out  1  beat direction
- mem_addr_o  out  32  beat address
- mem_wdata_o  out  DATA_W  beat write data
- mem_valid_i  in  1  memory beat completion pulse
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_valid_i

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; latched address, direction and count 0.
- States:
  - IDLE: if any req_i is set, pick the first set bit searching upward from ptr with wraparound. Latch the winner index, addr_i, wr_i and beats_i (0 becomes 256), then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: gnt_o[win]=1, busy_o=1, mem_req_o=1. mem_addr_o and mem_wr_o come from registers. mem_wdata_o = wdata_i slice of the winner, combinational and live. On mem_valid_i:
    - Not the last beat: address += LINE_BYTES, remaining -= 1, stay in ISSUE. The new address is presented the next cycle.
    - Last beat: go to RELEASE.
  - RELEASE: gnt_o=0, busy_o=0, mem_req_o=0; ptr = (win+1) mod NUM_REQ; go to IDLE.
- Latency: req_i rising in cycle N gives gnt_o and mem_req_o in cycle N+1.
- Minimum gap between bursts is two cycles (RELEASE, then IDLE).
- beat_done_o = gnt_o & {NUM_REQ{mem_valid_i}}, combinational, in the same cycle as mem_valid_i.
- rdata_o = mem_rdata_i as a combinational passthrough; it is only meaningful when beat_done_o is set.
- The requester presents its next write line in the cycle after its beat_done_o.
- Address arithmetic is 32-bit and wraps modulo 2^32 with no error.
- Boundary conditions:
  - req_i dropped mid-burst: ignored; the burst runs to completion. Dropping req_i mid-burst is a requester protocol violation.
  - req_i changes, or a new requester raises req_i, while in ISSUE: no effect until the next IDLE evaluation.
  - mem_valid_i outside ISSUE: ignored; no beat_done_o.
  - Same requester re-requesting immediately: served again only if no other requester is pending.
  - Reset mid-burst: mem_req_o and gnt_o drop asynchronously; the burst is abandoned and no completion pulse is issued.

Optional Feature:
- Macro: FPU_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_busy_cycles_o [31:0] and perf_bursts_o [NUM_REQ*16-1:0].
  - perf_busy_cycles_o counts cycles in ISSUE, saturating at 0xFFFF_FFFF.
  - perf_bursts_o holds one 16-bit per-requester count of completed bursts, incremented on entry to RELEASE, wrapping.
  - Both counters clear on reset only.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
1. Single read: req_i=3'b001, addr 0x1000_0000, beats 3, mem_valid_i 2 cycles after each beat request -> mem_addr_o 0x1000_0000/0x1000_0040/0x1000_0080; three beat_done_o[0] pulses with matching rdata_o; gnt_o drops after the third.
2. Simultaneous: req_i=3'b111 from reset, beats 1 each -> grant order 0,1,2. With req_i held at 3'b111 the order continues 0,1,2 and no requester is granted twice in a row.
3. Write: requester 2, wr=1, beats 2, wdata changed after the first beat_done_o -> mem_wr_o=1 and mem_wdata_o shows line A then line B.
4. beats_i=0 -> exactly 256 beats issued; final address start+0x3FC0.
5. Reset asserted mid-burst after beat 1 of 4 -> gnt_o, mem_req_o, busy_o 0 immediately. After release, req from requester 1 is granted first with ptr=0 search.
6. Address wrap: start 0xFFFF_FFC0, beats 2 -> second beat address 0x0000_0000.
